shift_seq: RTL and testbench
============================

// Module: shift_seq
// PURPOSE
// Multi-step shift sequencer sitting directly upstream of the AMIN arithmetic card (1001).
// It takes a signed shift count, a shift type and a single/double flag, then sequences the
// card one bit per clock: SH alone (single) or AC:SH as a 32-bit pair, AC being the high word.
// It drives SHS/SHKL/SHX/SHM plus SL/M/S/ACKL/BC15/BC0 and reads back SH15/SH0/AC15/AC0.
// It reports BUSY, a one-cycle DONE and the last bit shifted out (LOUT).
// PARAMETERS
// CW   6   shift count width; CNT is two's complement, MSB = direction (0 left, 1 right)
// PORTS
// clk      in   1   system clock, all state on rising edge
// rst_n    in   1   asynchronous active-low reset
// START    in   1   start request, sampled only in IDLE
// CNT      in   CW  signed shift count, captured with START
// TYPE     in   2   0 logical, 1 rotate, 2 arithmetic, 3 link-fill; captured with START
// DBL      in   1   1 = double shift AC:SH, 0 = SH only; captured with START
// LINK_IN  in   1   fill bit for TYPE=3, sampled every shift cycle
// SH15,SH0 in   1   current SH register MSB/LSB from arithmetic card
// AC15,AC0 in   1   current AC register MSB/LSB from arithmetic card
// SHS      out  2   SH shift select: 01 left, 10 right, 00 idle (never 11)
// SHKL     out  1   SH clock enable
// SHX      out  1   bit entering SH[0] on left shift
// SHM      out  1   bit entering SH[15] on right shift
// SL       out  3   B-select: 5 AC-left, 4 AC-right, 0 otherwise
// M        out  1   ALU mode, 1 during double shift cycles
// S        out  4   ALU function, 4'hF (pass B) during double shift cycles
// ACKL     out  1   AC clock enable (double shifts only)
// BC15     out  1   bit entering AC[0] on double left (= SH15)
// BC0      out  1   bit entering AC[15] on double right
// BUSY     out  1   high from cycle after START accepted until DONE cycle inclusive
// DONE     out  1   one-cycle completion pulse
// LOUT     out  1   registered last bit shifted out
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, counter 0, LOUT 0; all outputs 0 immediately,
//   including mid-operation. The card keeps partially shifted data; no rollback.
// - States: IDLE, SHIFT, DONE.
//   - IDLE & START: capture dir=CNT[CW-1], n=|CNT| (unsigned CW bits; -32 -> 32),
//     TYPE, DBL. n=0 -> DONE, else SHIFT.
//   - SHIFT: one shift per cycle, n decrements. When the strobe is issued with n==1 -> DONE.
//   - DONE: DONE=1 for one cycle -> IDLE. START ignored in SHIFT/DONE.
// - Latency: START at edge 0; strobes on cycles 1..n; DONE high in cycle n+1 (n=0: cycle 1).
// - Strobe outputs are Moore (decoded from state + captured regs), stable for a whole cycle.
//   SHKL=1 every SHIFT cycle. When DBL: ACKL=1, M=1, S=4'hF, SL=5 (left) or 4 (right).
// - Fill bit, left shift: logical 0; rotate SH15 (single) / AC15 (double); arith 0; link LINK_IN.
//   Goes to SHX; with DBL, BC15=SH15.
// - Fill bit, right shift: logical 0; rotate SH0; arith SH15 (single) / AC15 (double); link LINK_IN.
//   Goes to SHM (single), or to BC0 with SHM=AC0 (double).
// - LOUT: loaded each SHIFT cycle with the outgoing bit: left SH15 (single) / AC15 (double),
//   right SH0. Held otherwise; unchanged on n=0.
// - Outside SHIFT all strobe/fill outputs are 0.
// TESTING
// 1. Single logical left, CNT=3, SH=16'h8001 -> SHKL high 3 cycles, SH=16'h0008, LOUT=0, DONE cycle 4.
// 2. Single arith right, CNT=-2 (6'o76), SH=16'h8004 -> SH=16'hE001, LOUT=0; SHS=10 both cycles.
// 3. Double rotate left, CNT=4, AC=16'hF000, SH=16'h0001 -> AC=16'h0000, SH=16'h001F; ACKL/SL=5 x4.
// 4. CNT=0 with START -> no SHKL/ACKL, DONE in cycle 1, BUSY 1 cycle, LOUT unchanged.
// 5. CNT=-32 single link right, LINK_IN=1, SH=0 -> 32 strobes, SH=16'hFFFF, DONE cycle 33.
// 6. rst_n low at strobe 2 of CNT=5 -> all outputs 0 at once; START after release runs a full new op.

Source files
------------

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - bit-serial shift sequencer driving the SH / AC:SH registers of the arithmetic card
// One shift strobe per clock; strobes are decoded from state and captured controls, fill bits from card feedback.
module shift_seq #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          START,
    input  logic [CW-1:0] CNT,
    input  logic [1:0]    TYPE,
    input  logic          DBL,
    input  logic          LINK_IN,
    input  logic          SH15,
    input  logic          SH0,
    input  logic          AC15,
    input  logic          AC0,
    output logic [1:0]    SHS,
    output logic          SHKL,
    output logic          SHX,
    output logic          SHM,
    output logic [2:0]    SL,
    output logic          M,
    output logic [3:0]    S,
    output logic          ACKL,
    output logic          BC15,
    output logic          BC0,
    output logic          BUSY,
    output logic          DONE,
    output logic          LOUT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] TY_LOGICAL = 2'd0;
    localparam logic [1:0] TY_ROTATE  = 2'd1;
    localparam logic [1:0] TY_ARITH   = 2'd2;
    localparam logic [1:0] TY_LINK    = 2'd3;

    state_t        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic          dir_q, dir_d;
    logic [1:0]    type_q, type_d;
    logic          dbl_q, dbl_d;
    logic          lout_q, lout_d;

    logic [CW-1:0] cnt_abs;
    logic          shifting;
    logic          dbl_shift;
    logic          fill_left;
    logic          fill_right;
    logic          out_bit;

    // Magnitude stays unsigned in CW bits, so the most negative count maps to 2^(CW-1).
    assign cnt_abs = CNT[CW-1] ? (~CNT + CW'(1)) : CNT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            dir_q   <= 1'b0;
            type_q  <= TY_LOGICAL;
            dbl_q   <= 1'b0;
            lout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            dir_q   <= dir_d;
            type_q  <= type_d;
            dbl_q   <= dbl_d;
            lout_q  <= lout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        dir_d   = dir_q;
        type_d  = type_q;
        dbl_d   = dbl_q;
        lout_d  = lout_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    dir_d   = CNT[CW-1];
                    n_d     = cnt_abs;
                    type_d  = TYPE;
                    dbl_d   = DBL;
                    state_d = (cnt_abs == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                n_d    = n_q - CW'(1);
                lout_d = out_bit;
                if (n_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign shifting  = (state_q == ST_SHIFT);
    assign dbl_shift = shifting && dbl_q;

    // Fill sources come straight from the card so they track the word being shifted this cycle.
    always_comb begin
        fill_left = 1'b0;
        case (type_q)
            TY_LOGICAL: fill_left = 1'b0;
            TY_ROTATE:  fill_left = dbl_q ? AC15 : SH15;
            TY_ARITH:   fill_left = 1'b0;
            TY_LINK:    fill_left = LINK_IN;
            default:    fill_left = 1'b0;
        endcase
    end

    always_comb begin
        fill_right = 1'b0;
        case (type_q)
            TY_LOGICAL: fill_right = 1'b0;
            TY_ROTATE:  fill_right = SH0;
            TY_ARITH:   fill_right = dbl_q ? AC15 : SH15;
            TY_LINK:    fill_right = LINK_IN;
            default:    fill_right = 1'b0;
        endcase
    end

    assign out_bit = dir_q ? SH0 : (dbl_q ? AC15 : SH15);

    always_comb begin
        SHS  = 2'b00;
        SHKL = 1'b0;
        SHX  = 1'b0;
        SHM  = 1'b0;
        SL   = 3'd0;
        M    = 1'b0;
        S    = 4'h0;
        ACKL = 1'b0;
        BC15 = 1'b0;
        BC0  = 1'b0;
        if (shifting) begin
            SHKL = 1'b1;
            SHS  = dir_q ? 2'b10 : 2'b01;
            if (!dir_q) begin
                SHX  = fill_left;
                BC15 = dbl_q ? SH15 : 1'b0;
            end else begin
                // Double right: the fill enters AC[15] and AC's low bit carries into SH[15].
                SHM = dbl_q ? AC0 : fill_right;
                BC0 = dbl_q ? fill_right : 1'b0;
            end
        end
        if (dbl_shift) begin
            ACKL = 1'b1;
            M    = 1'b1;
            S    = 4'hF;
            SL   = dir_q ? 3'd4 : 3'd5;
        end
    end

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = (state_q == ST_DONE);
    assign LOUT = lout_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - self-checking bench for shift_seq with a bit-level model of the SH/AC card
module tb_shift_seq;

    logic       clk;
    logic       rst_n;
    logic       START;
    logic [5:0] CNT;
    logic [1:0] TYP;
    logic       DBL;
    logic       LINK_IN;
    logic       SH15, SH0, AC15, AC0;
    logic [1:0] SHS;
    logic       SHKL, SHX, SHM;
    logic [2:0] SL;
    logic       M;
    logic [3:0] S;
    logic       ACKL, BC15, BC0, BUSY, DONE, LOUT;

    shift_seq #(.CW(6)) dut (
        .clk(clk), .rst_n(rst_n), .START(START), .CNT(CNT), .TYPE(TYP), .DBL(DBL),
        .LINK_IN(LINK_IN), .SH15(SH15), .SH0(SH0), .AC15(AC15), .AC0(AC0),
        .SHS(SHS), .SHKL(SHKL), .SHX(SHX), .SHM(SHM), .SL(SL), .M(M), .S(S),
        .ACKL(ACKL), .BC15(BC15), .BC0(BC0), .BUSY(BUSY), .DONE(DONE), .LOUT(LOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic card: SH and AC registers reacting to the sequencer strobes.
    logic [15:0] sh_m, ac_m, ld_sh, ld_ac;
    logic        ld;

    always @(posedge clk) begin
        if (ld) begin
            sh_m <= ld_sh;
            ac_m <= ld_ac;
        end else begin
            if (SHKL) begin
                if (SHS == 2'b01) sh_m <= {sh_m[14:0], SHX};
                else if (SHS == 2'b10) sh_m <= {SHM, sh_m[15:1]};
            end
            if (ACKL) begin
                if (SL == 3'd5) ac_m <= {ac_m[14:0], BC15};
                else if (SL == 3'd4) ac_m <= {BC0, ac_m[15:1]};
            end
        end
    end

    assign SH15 = sh_m[15];
    assign SH0  = sh_m[0];
    assign AC15 = ac_m[15];
    assign AC0  = ac_m[0];

    typedef struct {
        logic [5:0]  cnt;
        logic [1:0]  typ;
        logic        dbl;
        logic        link;
        logic [15:0] ac0;
        logic [15:0] sh0;
        logic [15:0] exp_ac;
        logic [15:0] exp_sh;
        logic        exp_lout;
        int          n;
    } vec_t;

    vec_t vec [12];
    vec_t sb [$];

    int checks;
    int errors;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input int idx);
        vec_t v, e;
        int k, strobes, busy, bad, done_at;
        logic [2:0] exp_sl;
        logic [1:0] exp_shs;
        v = vec[idx];
        exp_shs = v.cnt[5] ? 2'b10 : 2'b01;
        exp_sl  = v.dbl ? (v.cnt[5] ? 3'd4 : 3'd5) : 3'd0;
        @(negedge clk);
        ld = 1'b1; ld_sh = v.sh0; ld_ac = v.ac0;
        @(negedge clk);
        ld = 1'b0;
        START = 1'b1; CNT = v.cnt; TYP = v.typ; DBL = v.dbl; LINK_IN = v.link;
        sb.push_back(v);
        @(negedge clk);
        START = 1'b0;
        k = 1; strobes = 0; busy = 0; bad = 0; done_at = 0;
        while (done_at == 0 && k <= 70) begin
            if (SHKL) begin
                strobes++;
                if (SHS != exp_shs || ACKL != v.dbl || M != v.dbl || SL != exp_sl ||
                    S != (v.dbl ? 4'hF : 4'h0)) bad++;
            end else if (SHS != 2'b00 || ACKL || SHX || SHM || BC15 || BC0 || M || S != 4'h0 || SL != 3'd0) begin
                bad++;
            end
            if (BUSY) busy++;
            if (DONE) done_at = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        e = sb.pop_front();
        chk($sformatf("v%0d done_cycle", idx), done_at, e.n + 1);
        chk($sformatf("v%0d strobes", idx), strobes, e.n);
        chk($sformatf("v%0d busy_cycles", idx), busy, e.n + 1);
        chk($sformatf("v%0d strobe_sigs", idx), bad, 0);
        chk($sformatf("v%0d sh", idx), int'(sh_m), int'(e.exp_sh));
        chk($sformatf("v%0d ac", idx), int'(ac_m), int'(e.exp_ac));
        chk($sformatf("v%0d lout", idx), int'(LOUT), int'(e.exp_lout));
        @(negedge clk);
        chk($sformatf("v%0d idle_busy", idx), int'(BUSY), 0);
    endtask

    initial begin
        checks = 0; errors = 0;
        //         cnt     typ   dbl   link  ac0       sh0       exp_ac    exp_sh    lout  n
        vec[0]  = '{6'd3,  2'd0, 1'b0, 1'b0, 16'h1234, 16'h8001, 16'h1234, 16'h0008, 1'b0, 3};
        vec[1]  = '{6'o76, 2'd2, 1'b0, 1'b0, 16'h0000, 16'h8004, 16'h0000, 16'hE001, 1'b0, 2};
        vec[2]  = '{6'd4,  2'd1, 1'b1, 1'b0, 16'hF000, 16'h0001, 16'h0000, 16'h001F, 1'b1, 4};
        vec[3]  = '{6'd0,  2'd0, 1'b0, 1'b0, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 1'b1, 0};
        vec[4]  = '{6'o40, 2'd3, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 32};
        vec[5]  = '{6'o75, 2'd0, 1'b1, 1'b0, 16'h8001, 16'h0004, 16'h1000, 16'h2000, 1'b1, 3};
        vec[6]  = '{6'o74, 2'd2, 1'b1, 1'b0, 16'h8000, 16'h0000, 16'hF800, 16'h0000, 1'b0, 4};
        vec[7]  = '{6'o77, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 1'b1, 1};
        vec[8]  = '{6'd2,  2'd3, 1'b0, 1'b1, 16'h0000, 16'h4000, 16'h0000, 16'h0003, 1'b1, 2};
        vec[9]  = '{6'd1,  2'd3, 1'b1, 1'b1, 16'h0000, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1};
        vec[10] = '{6'd1,  2'd2, 1'b0, 1'b0, 16'h0000, 16'hC000, 16'h0000, 16'h8000, 1'b1, 1};
        vec[11] = '{6'o77, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1};

        rst_n = 1'b0; START = 1'b0; CNT = '0; TYP = '0; DBL = 1'b0; LINK_IN = 1'b0;
        ld = 1'b1; ld_sh = '0; ld_ac = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_done", int'(DONE), 0);
        chk("reset_lout", int'(LOUT), 0);
        chk("reset_strobes", int'({SHS, SHKL, ACKL, SL, M, S}), 0);
        rst_n = 1'b1;
        ld = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(i);
        end

        // Asynchronous reset during the second strobe of a five-step shift.
        @(negedge clk);
        ld = 1'b1; ld_sh = 16'h8001; ld_ac = 16'h0000;
        @(negedge clk);
        ld = 1'b0; START = 1'b1; CNT = 6'd5; TYP = 2'd0; DBL = 1'b0; LINK_IN = 1'b0;
        @(negedge clk);
        START = 1'b0;
        @(negedge clk);
        chk("rst_mid_strobe2", int'(SHKL), 1);
        chk("rst_mid_lout_before", int'(LOUT), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", int'({SHS, SHKL, SHX, SHM, ACKL, SL, M, S, BC15, BC0}), 0);
        chk("rst_mid_busy_done", int'({BUSY, DONE}), 0);
        chk("rst_mid_lout", int'(LOUT), 0);
        repeat (2) @(negedge clk);
        chk("rst_mid_sh_kept", int'(sh_m), 16'h0002);
        rst_n = 1'b1;
        run_op(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
